// File: rtl/fsx_pkg.sv
// Shared constants and types for the frame synthesizer VRAM write path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: VRAM region encodings (in_addr[15:14]), the VRAM word address
// width, and the drain FSM state type with its state constants.
package fsx_pkg;

  localparam int VRAM_AW = 14;

  localparam logic [1:0] REGION_VRAM32 = 2'b00;
  localparam logic [1:0] REGION_VRAM8  = 2'b01;
  localparam logic [1:0] REGION_SPR    = 2'b10;

  typedef logic [0:0] wq_state_t;
  localparam wq_state_t S_IDLE  = 1'b0;
  localparam wq_state_t S_DRAIN = 1'b1;

endpackage

// File: rtl/vram_wq_fifo.sv
// Synchronous circular FIFO holding {addr, data} VRAM write entries.
// Latency: an entry pushed at edge N is visible on pop_dat after edge N.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports:
//   vga_clk, rst_n     clock, asynchronous active-low reset (pointers cleared)
//   push, push_dat     write request and entry
//   pop, pop_dat       read request; pop_dat is the current head (combinational)
//   full, empty, level occupancy status derived from the registered pointers
module vram_wq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48
) (
  input  logic                     vga_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: a reset flush only needs the pointers cleared.
  always_ff @(posedge vga_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/vram_write_queue.sv
// Buffers CPU VRAM writes and drains them (one per cycle) into vram32/vram8/sprite VRAM write ports.
// Latency: entry accepted at edge N pops at edge N+1; strobe visible after that edge for one cycle.
// Backpressure: in_ready = (level != DEPTH); a push while full is refused even if a pop occurs.
//
// Ports:
//   vga_clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_addr/in_data  write request; in_addr[15:14] region, [13:0] word address
//   frameDrawn                     frame-complete pulse; its rising edge opens the drain window
//   wr_addr/wr_data                shared registered write address/data for all VRAMs
//   vram32_we/vram8_we/vramSPR_we  one-cycle write strobes, at most one per pop
//   level                          FIFO occupancy
//   drop                           one-cycle pulse when a region-11 entry is popped and discarded
//
// Build option VRAM_VBLANK_ONLY_EN: when defined, draining is confined to a
// DRAIN_CYCLES-long window after each frameDrawn rising edge; when undefined,
// the queue drains whenever it is non-empty and frameDrawn is ignored.
module vram_write_queue
  import fsx_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 16000
) (
  input  logic                   vga_clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_addr,
  input  logic [31:0]            in_data,
  input  logic                   frameDrawn,
  output logic [VRAM_AW-1:0]     wr_addr,
  output logic [31:0]            wr_data,
  output logic                   vram32_we,
  output logic                   vram8_we,
  output logic                   vramSPR_we,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push_acc;
  logic          pop_en;
  logic          permit;
  logic [47:0]   head;
  logic [LW-1:0] level_nxt;
  wq_state_t     state;
  wq_state_t     state_nxt;

  assign in_ready = ~fifo_full;
  assign push_acc = in_valid & in_ready;

  vram_wq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (48)
  ) u_fifo (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .push     (push_acc),
    .push_dat ({in_addr, in_data}),
    .pop      (pop_en),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

`ifdef VRAM_VBLANK_ONLY_EN
  localparam logic [14:0] DRAIN_LOAD = 15'(DRAIN_CYCLES);

  logic        fd_q;
  logic [14:0] win_cnt;

  // A rising edge always reloads the full window, even if one is still open.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      fd_q    <= 1'b0;
      win_cnt <= '0;
    end else begin
      fd_q <= frameDrawn;
      if (frameDrawn && !fd_q) begin
        win_cnt <= DRAIN_LOAD;
      end else if (win_cnt != 15'd0) begin
        win_cnt <= win_cnt - 15'd1;
      end
    end
  end

  // The pop on the edge where the counter goes 1->0 is the last one allowed.
  assign permit = (win_cnt != 15'd0);
`else
  localparam int unused_drain_cycles = DRAIN_CYCLES;
  logic unused_frame_drawn;
  assign unused_frame_drawn = frameDrawn;
  assign permit = 1'b1;
`endif

  // Both states pop straight away when allowed: an entry pushed while IDLE
  // must still pop on the very next edge, so IDLE->DRAIN carries a pop.
  always_comb begin
    pop_en    = 1'b0;
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  pop_en = permit & ~fifo_empty;
      S_DRAIN: pop_en = permit & ~fifo_empty;
      default: pop_en = 1'b0;
    endcase
    level_nxt = level + LW'(push_acc) - LW'(pop_en);
    if (pop_en && (level_nxt != '0)) state_nxt = S_DRAIN;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      wr_data    <= '0;
      vram32_we  <= 1'b0;
      vram8_we   <= 1'b0;
      vramSPR_we <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state      <= state_nxt;
      vram32_we  <= 1'b0;
      vram8_we   <= 1'b0;
      vramSPR_we <= 1'b0;
      drop       <= 1'b0;
      if (pop_en) begin
        wr_addr <= head[32 +: VRAM_AW];
        wr_data <= head[31:0];
        case (head[47:46])
          REGION_VRAM32: vram32_we  <= 1'b1;
          REGION_VRAM8:  vram8_we   <= 1'b1;
          REGION_SPR:    vramSPR_we <= 1'b1;
          default:       drop       <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/vram_write_queue.md
# vram_write_queue

Buffers CPU-side VRAM writes and drains them into the write ports of the background/window VRAM (both 32-bit copies), the 8-bit tile VRAM and the sprite VRAM. It sits directly upstream of the frame synthesizer's VRAM read ports and uses its `frameDrawn` pulse to confine updates to vertical blanking. This prevents tearing and mid-line attribute changes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two ≥ 2.
- `DRAIN_CYCLES`, 16000: length of the drain window after a `frameDrawn` rising edge, in `vga_clk` cycles. Range 1..32767.

Ports:
- `vga_clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: write request.
- `in_ready`, out, 1: queue can accept.
- `in_addr`, in, 16: [15:14] region (00 vram32, 01 vram8, 10 vramSPR, 11 invalid), [13:0] word address.
- `in_data`, in, 32: write data; vram8 uses [7:0], vramSPR uses [8:0].
- `frameDrawn`, in, 1: frame-complete pulse from the frame synthesizer, 8 cycles high.
- `wr_addr`, out, 14: shared VRAM write address.
- `wr_data`, out, 32: shared VRAM write data; narrow RAMs take low bits.
- `vram32_we`, out, 1: write strobe to both vram32 and vram322 (kept identical).
- `vram8_we`, out, 1: write strobe, 8-bit VRAM.
- `vramSPR_we`, out, 1: write strobe, sprite VRAM.
- `level`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `drop`, out, 1: one-cycle pulse when an accepted entry with region 11 is discarded.

## Operation
- A transfer is accepted when `in_valid && in_ready` on a clock edge. `in_ready = (level != DEPTH)`, derived combinationally from the registered count. The FIFO is circular, with pointers one bit wider than the index.
- Drain FSM states:
  - `S_IDLE`: FIFO empty or drain not permitted.
  - `S_DRAIN`: pop one entry per cycle while drain is permitted and the FIFO is non-empty.
  - Transitions: IDLE→DRAIN when permitted and non-empty. DRAIN→IDLE when the pop empties the FIFO or permission drops.
- Pop action: register `wr_addr`/`wr_data` from the entry and assert exactly one `*_we` according to the region. Region 11 asserts no strobe and pulses `drop` instead.
- Window counter, 15 bits:
  - Loads `DRAIN_CYCLES` on a `frameDrawn` rising edge, detected against a registered copy of `frameDrawn`.
  - Decrements to 0 otherwise. Drain is permitted while the counter is non-zero.
  - A rising edge while the window is open reloads the counter; it does not extend by adding.
- Simultaneous push and pop: `level` is unchanged and both pointers advance. When full, a push is refused even if a pop occurs in the same cycle.
- Entries drain in strict FIFO order; there is no reordering between regions.

## Timing
Reset values:
- Outputs: `in_ready`=1, `wr_addr`=0, `wr_data`=0, all `*_we`=0, `drop`=0, `level`=0.
- Internal: FSM=`S_IDLE`, window counter=0, pointers=0.

Latency:
- An entry accepted at edge N can be popped at edge N+1. Its strobe is visible after edge N+1 and is held for exactly one cycle.
- The first strobe of a window is visible 2 cycles after the `frameDrawn` rising edge is sampled: one cycle for edge detect, one for pop.

Window and reset edges:
- The last permitted pop happens at the edge where the counter goes 1→0.
- Reset mid-drain flushes the FIFO (contents lost), clears strobes immediately, and closes the window.

## Configuration
- `VRAM_VBLANK_ONLY_EN` defined: drain is permitted only inside the window described above.
- `VRAM_VBLANK_ONLY_EN` undefined: the window counter and edge detect are removed and drain is permitted whenever the FIFO is non-empty. `frameDrawn` is ignored.

## Structure
- Shared package `fsx_pkg`:
  - Region encoding constants `REGION_VRAM32=2'b00`, `REGION_VRAM8=2'b01`, `REGION_SPR=2'b10`.
  - The FSM state typedef.
  - `VRAM_AW=14`.
- One sub-module, `vram_wq_fifo`: a synchronous FIFO with `level`, push/pop, and full/empty. It is parameterised by `DEPTH` and width 48 (16-bit address + 32-bit data).

## Test plan
- **Reset:** assert `rst_n`=0 mid-drain with 5 entries queued → all strobes 0 in the same cycle; after release `level`=0 and `in_ready`=1.
- **Region routing:**
  - Push 0x0123 / 0xDEADBEEF, 0x4010 / 0xAB, 0x8005 / 0x1FF, then pulse `frameDrawn`.
  - Expected: `vram32_we` with addr 0x0123, data 0xDEADBEEF; then `vram8_we` with addr 0x0010; then `vramSPR_we` with addr 0x0005, data[8:0]=0x1FF.
  - The three strobes occur on consecutive cycles, starting 2 cycles after the rising edge.
- **Full:** with DEPTH=16 and no window, 17 back-to-back pushes → `in_ready` low after the 16th, the 17th is not accepted, `level`=16.
- **Window expiry:** DRAIN_CYCLES=3, 10 entries queued → exactly 3 strobes, then `level`=7 until the next `frameDrawn`.
- **Invalid region:** push 0xC000 → on pop, `drop` pulses once with no strobe and `level` decrements.
- **Macro undefined:** push 1 entry with `frameDrawn` held 0 → strobe on the cycle after the accept edge.
